// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : PC generator and fetch stage in front of the instruction
//                BRAM read port. Issues reads, captures the 1-cycle-latency
//                read data and hands {pc, instr} to decode over valid/ready.
//                Redirects from execute flush in-flight words; a misaligned
//                redirect target latches a sticky fault that halts fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // Next fetch address and the address of the word sitting in the BRAM output
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;

    // Output register towards decode
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;

    // Sticky misaligned-redirect flag
    logic        r_fault;

    logic        w_redirect_bad;
    logic        w_redirect_ok;
    logic        w_capture;
    logic        w_can_issue;
    logic        w_issue;
    logic [31:0] w_issue_pc;

    // Capture / issue decisions; a redirect overrides the normal flow and
    // reset gates the BRAM enable so no read is issued while held in reset
    always_comb begin
        w_redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
        w_redirect_ok  = redirect_valid & ~w_redirect_bad;
        w_capture      = r_inflight & (~r_out_valid | if_ready) & ~redirect_valid;
        w_can_issue    = rst_n & fetch_en & ~r_fault;
        if (redirect_valid) begin
            w_issue = w_can_issue & w_redirect_ok;
        end else begin
            // Never issue over a BRAM word that has not been captured yet
            w_issue = w_can_issue & (~r_inflight | w_capture);
        end
        w_issue_pc = w_redirect_ok ? redirect_pc : r_pc;
    end

    assign imem_en   = w_issue;
    assign imem_addr = w_issue_pc;

    // PC, in-flight tracking and fault state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
            r_fault       <= 1'b0;
        end else begin
            if (w_redirect_bad) begin
                r_fault <= 1'b1;
            end
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= w_issue_pc;
                r_pc          <= w_issue_pc + c_PC_STEP;
            end else if (w_redirect_ok) begin
                // Redirect while fetch is held: remember the target for resume
                r_inflight <= 1'b0;
                r_pc       <= redirect_pc;
            end else if (redirect_valid || w_capture) begin
                // Misaligned redirect keeps r_pc; either way the BRAM word is gone
                r_inflight <= 1'b0;
            end
        end
    end

    // Output valid: cleared by flush or by a completed handshake with nothing to refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
        end else if (if_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output payload: load the BRAM word and its address on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_instr <= 32'h0000_0000;
            r_out_pc    <= 32'h0000_0000;
        end else if (w_capture) begin
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_inflight_pc;
        end
    end

    assign if_valid = r_out_valid;
    assign if_instr = r_out_instr;
    assign if_pc    = r_out_pc;
    assign fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch: reset/stream
//                vector table, hand-written corner sequences, and a random
//                phase scored against an in-order PC-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1-cycle read latency, output held while not enabled
    logic [31:0] mem [0:1023];
    logic [31:0] bram_q;
    initial bram_q = 32'h0;
    always @(posedge clk) begin
        if (imem_en) bram_q <= mem[imem_addr[11:2]];
    end
    assign imem_rdata = bram_q;

    int n_checks;
    int n_err;
    int n_xfer;

    // Reference model: decode must see an unbroken +4 PC stream that restarts
    // at every aligned redirect target and at RESET_PC after reset
    logic [31:0] exp_pc;
    bit          hold_prev;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard step, called at the sampling point of every cycle
    task automatic score();
        if (!rst_n) begin
            exp_pc    = RESET_PC;
            hold_prev = 1'b0;
            return;
        end
        if (hold_prev) begin
            check(if_valid && if_pc == hold_pc && if_instr == hold_instr, "stall_hold",
                  {if_valid, if_pc, if_instr}, {1'b1, hold_pc, hold_instr});
        end
        if (fault) begin
            check(!imem_en && !if_valid, "fault_quiet", {imem_en, if_valid}, 2'b00);
        end
        if (if_valid && if_ready) begin
            check(if_pc == exp_pc && if_instr == mem[if_pc[11:2]], "stream_order",
                  {if_pc, if_instr}, {exp_pc, mem[exp_pc[11:2]]});
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (redirect_valid && redirect_pc[1:0] == 2'b00 && !fault) begin
            exp_pc = redirect_pc;
        end
        hold_prev  = if_valid && !if_ready && !redirect_valid;
        hold_pc    = if_pc;
        hold_instr = if_instr;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        score();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst_n;
        bit          fe;
        bit          rdy;
        bit          en;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] instr;
        bit          flt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        n_checks = 0; n_err = 0; n_xfer = 0;
        exp_pc = RESET_PC; hold_prev = 1'b0; hold_pc = 0; hold_instr = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 | k;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h0070_0193;
        mem[2] = 32'h0031_0233;
        mem[3] = 32'h0000_006F;

        //            rst fe rdy en addr          valid pc            instr          flt
        vecs[0] = '{1'b0, 1, 1, 0, 32'h0,       0, 32'h0,        32'h0,         0};
        vecs[1] = '{1'b1, 1, 1, 1, 32'h0,       0, 32'h0,        32'h0,         0};
        vecs[2] = '{1'b1, 1, 1, 1, 32'h4,       0, 32'h0,        32'h0,         0};
        vecs[3] = '{1'b1, 1, 1, 1, 32'h8,       1, 32'h0,        32'h0050_0113, 0};
        vecs[4] = '{1'b1, 1, 1, 1, 32'hC,       1, 32'h4,        32'h0070_0193, 0};
        vecs[5] = '{1'b1, 1, 1, 1, 32'h10,      1, 32'h8,        32'h0031_0233, 0};
        vecs[6] = '{1'b1, 1, 1, 1, 32'h14,      1, 32'hC,        32'h0000_006F, 0};

        rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state and first four words streamed back-to-back
        for (int i = 0; i < 7; i++) begin
            rst_n = vecs[i].rst_n; fetch_en = vecs[i].fe; if_ready = vecs[i].rdy;
            settle();
            check(imem_en == vecs[i].en && (!vecs[i].en || imem_addr == vecs[i].addr) &&
                  if_valid == vecs[i].valid && if_pc == vecs[i].pc &&
                  if_instr == vecs[i].instr && fault == vecs[i].flt,
                  $sformatf("vec%0d", i),
                  {imem_en, imem_addr, if_valid, if_pc, if_instr, fault},
                  {vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].instr, vecs[i].flt});
            advance();
        end

        // Backpressure: output frozen at 0x10, no issue while the BRAM word waits
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check(if_valid && if_pc == 32'h10 && !imem_en, "bp_frozen",
                  {if_valid, if_pc, imem_en}, {1'b1, 32'h10, 1'b0});
            advance();
        end
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check(if_valid && if_pc == 32'h10 + 4 * i, "bp_resume",
                  {if_valid, if_pc}, {1'b1, 32'h10 + 32'(4 * i)});
            advance();
        end

        // Redirect to 0x40 while 0x4 is on the output and 0x8 in flight
        rst_n = 1'b0; settle(); advance(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        settle();
        check(imem_en && imem_addr == 32'h40 && if_valid && if_pc == 32'h4, "redir_issue",
              {imem_en, imem_addr, if_valid, if_pc}, {1'b1, 32'h40, 1'b1, 32'h4});
        advance();
        redirect_valid = 1'b0; if_ready = 1'b1;
        settle();
        check(!if_valid, "redir_flush", if_valid, 1'b0);
        advance();
        settle();
        check(if_valid && if_pc == 32'h40, "redir_first", {if_valid, if_pc}, {1'b1, 32'h40});
        advance();
        settle();
        check(if_valid && if_pc == 32'h44, "redir_second", {if_valid, if_pc}, {1'b1, 32'h44});
        advance();

        // Misaligned redirect: sticky fault, fetch halted until reset
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        settle(); advance();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check(fault && !if_valid && !imem_en, "fault_halt",
                  {fault, if_valid, imem_en}, {1'b1, 1'b0, 1'b0});
            advance();
        end
        rst_n = 1'b0;
        settle();
        check(!fault && !imem_en, "fault_reset", {fault, imem_en}, 2'b00);
        advance();
        rst_n = 1'b1;

        // Asynchronous reset between edges while streaming
        for (int i = 0; i < 4; i++) begin settle(); advance(); end
        #3;
        rst_n = 1'b0;
        #1;
        check(!if_valid && !imem_en && !fault && if_pc == 32'h0, "async_reset",
              {if_valid, imem_en, fault, if_pc}, {1'b0, 1'b0, 1'b0, 32'h0});
        settle(); advance();
        rst_n = 1'b1;
        settle();
        check(imem_en && imem_addr == RESET_PC, "reset_first_addr",
              {imem_en, imem_addr}, {1'b1, RESET_PC});
        advance();

        // Redirect to 0xFFFF_FFFC in the same cycle as a completing handshake
        settle(); advance();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        settle();
        check(if_valid && if_ready && if_pc == 32'h0, "redir_hs_word",
              {if_valid, if_pc}, {1'b1, 32'h0});
        advance();
        redirect_valid = 1'b0;
        settle(); advance();
        settle();
        check(if_valid && if_pc == 32'hFFFF_FFFC && if_instr == mem[1023], "wrap_top",
              {if_valid, if_pc, if_instr}, {1'b1, 32'hFFFF_FFFC, mem[1023]});
        advance();
        settle();
        check(if_valid && if_pc == 32'h0 && if_instr == 32'h0050_0113, "wrap_zero",
              {if_valid, if_pc, if_instr}, {1'b1, 32'h0, 32'h0050_0113});
        advance();

        // Random phase scored by the stream model
        n_xfer = 0;
        for (int i = 0; i < 1500; i++) begin
            fetch_en       = ($urandom_range(99) < 85);
            if_ready       = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 5);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            settle(); advance();
        end
        redirect_valid = 1'b0;
        check(n_xfer > 200, "random_progress", n_xfer, 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
